// File: rtl/qbert_pkg.sv
// qbert_pkg: definitions shared by the jump colour sequencer and its command queue.
//   seq_state_t    : sequencer FSM state encoding, also exported on the state_dbg port
//   JMP_UR..JMP_DL : the four legal jump direction codes
//   is_legal_jump  : true for codes 1..4; 0 and 5..7 are illegal
package qbert_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ISSUE      = 3'd1,
        WAIT_MOVE  = 3'd2,
        SETTLE     = 3'd3,
        UPDATE     = 3'd4,
        LEVEL_DONE = 3'd5,
        KO         = 3'd6
    } seq_state_t;

    localparam logic [2:0] JMP_UR = 3'd1;
    localparam logic [2:0] JMP_UL = 3'd2;
    localparam logic [2:0] JMP_DR = 3'd3;
    localparam logic [2:0] JMP_DL = 3'd4;

    function automatic logic is_legal_jump(input logic [2:0] code);
        return (code >= JMP_UR) && (code <= JMP_DL);
    endfunction

endpackage

// File: rtl/jump_cmd_fifo.sv
// jump_cmd_fifo: small synchronous FIFO that holds queued jump codes.
// Ports:
//   clk, reset       : rising-edge clock, synchronous active-high reset
//   push / wr_data   : write strobe and data; ignored while full
//   pop  / rd_data   : read strobe; rd_data always shows the oldest entry (show-ahead)
//   flush            : empties the queue; wins over a same-cycle push or pop
//   full / empty     : decoded from the registered occupancy count
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module jump_cmd_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    input  logic             flush,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign rd_data = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            // Simultaneous push and pop leave the occupancy unchanged.
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/jump_color_sequencer.sv
// jump_color_sequencer: queues NIOS jump commands, issues them one at a time to the
// qbert movement layer, waits for the landing and colours the cube that was hit.
// Build option: define COLOR_TOGGLE_EN to make a landing invert the cube colour bit;
// by default a landing sets the bit and it stays set until restart.
// Ports:
//   CLK_33, reset            : sole clock, synchronous active-high reset
//   cmd_valid/cmd_jump       : jump command offer; cmd_ready = queue not full
//   pause                    : holds off issuing new jumps (does not abort one in flight)
//   restart                  : one-cycle pulse, flushes queue, clears colours, back to IDLE
//   done_move, KO_qb         : landing level and fall/hit indication from the qbert layer
//   position_qb              : per-cube hit flags sampled in UPDATE
//   e_start_qb, e_jump_qb    : jump start pulse and the code being executed
//   e_color_state            : per-cube colour bits
//   level_done, ko_flag      : all cubes coloured / halted on KO or timeout
//   jump_count               : landing counter (wraps, kept across restart)
//   state_dbg                : current FSM state
// Handshake: a command is taken on a rising CLK_33 edge where cmd_valid && cmd_ready
// and the code is legal; illegal codes and any offer made while in KO are dropped
// silently, and cmd_valid need not be held after the accepting edge.
module jump_color_sequencer
    import qbert_pkg::*;
#(
    parameter int N_cube     = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int SETTLE_CYC = 2,
    parameter int TIMEOUT    = 2**24
) (
    input  logic              CLK_33,
    input  logic              reset,
    input  logic              cmd_valid,
    input  logic [2:0]        cmd_jump,
    output logic              cmd_ready,
    input  logic              pause,
    input  logic              restart,
    input  logic              done_move,
    input  logic [3:0]        KO_qb,
    input  logic [N_cube-1:0] position_qb,
    output logic              e_start_qb,
    output logic [2:0]        e_jump_qb,
    output logic [N_cube-1:0] e_color_state,
    output logic              level_done,
    output logic              ko_flag,
    output logic [15:0]       jump_count,
    output seq_state_t        state_dbg
);

    localparam int IW = (N_cube > 1) ? $clog2(N_cube) : 1;

    seq_state_t        state_q, state_d;
    logic [2:0]        e_jump_q, e_jump_d;
    logic [N_cube-1:0] color_q, color_d;
    logic [15:0]       jump_cnt_q, jump_cnt_d;
    logic [31:0]       wait_cnt_q, wait_cnt_d;
    logic [31:0]       settle_cnt_q, settle_cnt_d;
    logic              done_prev_q;

    logic              fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
    logic [2:0]        fifo_rdata;
    logic              done_rise;
    logic              hit_found;
    logic [IW-1:0]     hit_idx;

    jump_cmd_fifo #(
        .WIDTH (3),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLK_33),
        .reset   (reset),
        .push    (fifo_push),
        .wr_data (cmd_jump),
        .pop     (fifo_pop),
        .rd_data (fifo_rdata),
        .flush   (fifo_flush),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign cmd_ready  = !fifo_full;
    assign fifo_push  = cmd_valid && is_legal_jump(cmd_jump) && (state_q != KO) && !restart;
    // Flushing on the KO entry edge as well keeps a same-cycle push out of the queue.
    assign fifo_flush = restart || (state_q == KO) || (state_d == KO);
    assign done_rise  = done_move && !done_prev_q;

    // Lowest set index of position_qb wins when several flags are up.
    always_comb begin
        hit_found = 1'b0;
        hit_idx   = '0;
        for (int i = N_cube - 1; i >= 0; i--) begin
            if (position_qb[i]) begin
                hit_found = 1'b1;
                hit_idx   = IW'(i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        e_jump_d     = e_jump_q;
        color_d      = color_q;
        jump_cnt_d   = jump_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        settle_cnt_d = settle_cnt_q;
        fifo_pop     = 1'b0;
        if (restart) begin
            state_d      = IDLE;
            color_d      = '0;
            wait_cnt_d   = '0;
            settle_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty && !pause) begin
                        fifo_pop = 1'b1;
                        e_jump_d = fifo_rdata;
                        state_d  = ISSUE;
                    end
                end
                ISSUE: begin
                    wait_cnt_d = '0;
                    state_d    = WAIT_MOVE;
                end
                WAIT_MOVE: begin
                    wait_cnt_d = wait_cnt_q + 32'd1;
                    if (KO_qb != 4'd0) begin
                        state_d = KO;
                    end else if (wait_cnt_q >= 32'(TIMEOUT - 1)) begin
                        state_d = KO;
                    end else if (done_rise) begin
                        settle_cnt_d = '0;
                        state_d      = (SETTLE_CYC == 0) ? UPDATE : SETTLE;
                    end
                end
                SETTLE: begin
                    settle_cnt_d = settle_cnt_q + 32'd1;
                    if (settle_cnt_q >= 32'(SETTLE_CYC - 1)) begin
                        state_d = UPDATE;
                    end
                end
                UPDATE: begin
                    if (!hit_found) begin
                        state_d = KO;
                    end else begin
`ifdef COLOR_TOGGLE_EN
                        color_d[hit_idx] = ~color_q[hit_idx];
`else
                        color_d[hit_idx] = 1'b1;
`endif
                        jump_cnt_d = jump_cnt_q + 16'd1;
                        state_d    = (&color_d) ? LEVEL_DONE : IDLE;
                    end
                end
                LEVEL_DONE: state_d = LEVEL_DONE;
                KO:         state_d = KO;
                default:    state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK_33) begin
        if (reset) begin
            state_q      <= IDLE;
            e_jump_q     <= '0;
            color_q      <= '0;
            jump_cnt_q   <= '0;
            wait_cnt_q   <= '0;
            settle_cnt_q <= '0;
            done_prev_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            e_jump_q     <= e_jump_d;
            color_q      <= color_d;
            jump_cnt_q   <= jump_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            done_prev_q  <= done_move;
        end
    end

    assign e_start_qb    = (state_q == ISSUE);
    assign e_jump_qb     = e_jump_q;
    assign e_color_state = color_q;
    assign level_done    = (state_q == LEVEL_DONE);
    assign ko_flag       = (state_q == KO);
    assign jump_count    = jump_cnt_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_jump_color_sequencer.sv
// tb_jump_color_sequencer: self-checking bench for jump_color_sequencer.
// Accepted jump codes go into exp_q; a monitor pops and compares on every e_start_qb.
module tb_jump_color_sequencer;
    import qbert_pkg::*;

    localparam int NC = 3;
    localparam int FD = 4;
    localparam int SC = 2;
    localparam int TO = 200;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic [2:0]    cmd_jump = '0;
    logic          cmd_ready;
    logic          pause = 1'b0;
    logic          restart = 1'b0;
    logic          done_move = 1'b0;
    logic [3:0]    ko_qb = '0;
    logic [NC-1:0] position_qb = '0;
    logic          e_start_qb;
    logic [2:0]    e_jump_qb;
    logic [NC-1:0] e_color_state;
    logic          level_done;
    logic          ko_flag;
    logic [15:0]   jump_count;
    seq_state_t    state_dbg;

    jump_color_sequencer #(
        .N_cube     (NC),
        .FIFO_DEPTH (FD),
        .SETTLE_CYC (SC),
        .TIMEOUT    (TO)
    ) dut (
        .CLK_33        (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_jump      (cmd_jump),
        .cmd_ready     (cmd_ready),
        .pause         (pause),
        .restart       (restart),
        .done_move     (done_move),
        .KO_qb         (ko_qb),
        .position_qb   (position_qb),
        .e_start_qb    (e_start_qb),
        .e_jump_qb     (e_jump_qb),
        .e_color_state (e_color_state),
        .level_done    (level_done),
        .ko_flag       (ko_flag),
        .jump_count    (jump_count),
        .state_dbg     (state_dbg)
    );

    // ---------------- scoreboard / model ----------------
    logic [2:0]    exp_q[$];
    int            checks = 0;
    int            errors = 0;
    int            model_occ = 0;
    logic          model_ko = 1'b0;
    logic [NC-1:0] model_color = '0;
    logic [15:0]   model_jumps = '0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // Every start pulse must match the oldest accepted command.
    always @(negedge clk) begin
        if (!reset && e_start_qb) begin
            if (exp_q.size() == 0) begin
                check("start_unexpected", 32'(e_start_qb), 32'd0);
            end else begin
                check("jump_code", 32'(e_jump_qb), 32'(exp_q.pop_front()));
                model_occ--;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] code);
        logic acc;
        acc = (code >= 3'd1) && (code <= 3'd4) && (model_occ < FD) && !model_ko;
        check("cmd_ready", 32'(cmd_ready), 32'(model_occ < FD));
        cmd_valid = 1'b1;
        cmd_jump  = code;
        tick();
        cmd_valid = 1'b0;
        if (acc) begin
            exp_q.push_back(code);
            model_occ++;
        end
    endtask

    task automatic wait_start();
        int n;
        n = 0;
        while (!e_start_qb && n < 300) begin
            tick();
            n++;
        end
        if (!e_start_qb) check("start_timeout", 32'(e_start_qb), 32'd1);
    endtask

    // Raise done_move with the given position; colour must change SC+1 edges after the rise edge.
    task automatic land(input logic [NC-1:0] pos);
        int idx;
        position_qb = pos;
        done_move   = 1'b1;
        repeat (SC + 1) tick();
        check("color_hold", 32'(e_color_state), 32'(model_color));
        tick();
        idx = -1;
        for (int i = NC - 1; i >= 0; i--) if (pos[i]) idx = i;
        if (idx >= 0) begin
`ifdef COLOR_TOGGLE_EN
            model_color[idx] = ~model_color[idx];
`else
            model_color[idx] = 1'b1;
`endif
            model_jumps++;
        end
        check("color_upd", 32'(e_color_state), 32'(model_color));
        check("jump_count", 32'(jump_count), 32'(model_jumps));
        check("level_done", 32'(level_done), 32'(&model_color));
        done_move = 1'b0;
    endtask

    task automatic do_restart();
        restart = 1'b1;
        tick();
        restart     = 1'b0;
        model_color = '0;
        model_ko    = 1'b0;
        model_occ   = 0;
        exp_q.delete();
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        check("rst_color", 32'(e_color_state), 32'd0);
        check("rst_ko", 32'(ko_flag), 32'd0);
        check("rst_level", 32'(level_done), 32'd0);
        check("rst_jcount", 32'(jump_count), 32'(model_jumps));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("reset_ready", 32'(cmd_ready), 32'd1);
        check("reset_start", 32'(e_start_qb), 32'd0);
        check("reset_jump", 32'(e_jump_qb), 32'd0);
        check("reset_color", 32'(e_color_state), 32'd0);
        check("reset_level", 32'(level_done), 32'd0);
        check("reset_ko", 32'(ko_flag), 32'd0);
        check("reset_jcount", 32'(jump_count), 32'd0);
        check("reset_state", 32'(state_dbg), 32'(IDLE));

        // Three jumps 1,3,2 landing on cubes 0,1,2 -> level done.
        pause = 1'b1;
        push(3'd1);
        push(3'd3);
        push(3'd2);
        pause = 1'b0;
        wait_start(); repeat (50) tick(); land(3'b001);
        wait_start(); repeat (50) tick(); land(3'b010);
        wait_start(); repeat (50) tick(); land(3'b100);
        check("level_state", 32'(state_dbg), 32'(((&model_color) != 0) ? LEVEL_DONE : IDLE));
        check("jcount_three", 32'(jump_count), 32'd3);
        do_restart();

        // Fill the queue; illegal codes must not take a slot.
        pause = 1'b1;
        push(3'd1);
        push(3'd2);
        push(3'd0);
        push(3'd7);
        push(3'd3);
        push(3'd4);
        push(3'd1);
        check("full_ready", 32'(cmd_ready), 32'd0);

        // KO while waiting, with the queue full again behind the issued jump.
        pause = 1'b0;
        wait_start();
        repeat (3) tick();
        push(3'd2);
        check("full_again", 32'(cmd_ready), 32'd0);
        ko_qb = 4'h1;
        tick();
        check("ko_flag", 32'(ko_flag), 32'd1);
        check("ko_state", 32'(state_dbg), 32'(KO));
        model_ko  = 1'b1;
        model_occ = 0;
        exp_q.delete();
        tick();
        check("ko_flushed", 32'(cmd_ready), 32'd1);
        push(3'd2);
        ko_qb = 4'h0;
        repeat (100) tick();
        check("ko_stays", 32'(state_dbg), 32'(KO));
        do_restart();

        // Pause blocks issue; release issues on the next cycle.
        pause = 1'b1;
        push(3'd3);
        repeat (100) tick();
        check("pause_idle", 32'(state_dbg), 32'(IDLE));
        pause = 1'b0;
        tick();
        check("pause_release", 32'(e_start_qb), 32'd1);
        repeat (50) tick();
        land(3'b010);
        repeat (3) tick();
        push(3'd4);
        wait_start(); repeat (50) tick(); land(3'b010);

        // Restart coincident with a done_move rising edge.
        repeat (3) tick();
        push(3'd1);
        wait_start();
        repeat (10) tick();
        position_qb = 3'b001;
        done_move   = 1'b1;
        do_restart();
        repeat (10) tick();
        check("rst_edge_idle", 32'(state_dbg), 32'(IDLE));
        check("rst_edge_jcount", 32'(jump_count), 32'(model_jumps));
        done_move = 1'b0;

        // No response at all -> timeout KO.
        push(3'd2);
        wait_start();
        repeat (TO + 5) tick();
        check("timeout_ko", 32'(ko_flag), 32'd1);
        model_ko = 1'b1;
        do_restart();

        repeat (5) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
